dco_freq_meter: RTL and testbench

- Measures the oscillation frequency of a DCO output by counting its rising edges over a programmable gate window of system-clock cycles.
- Produces a count result that loop logic or a host compares against the DCO control code.
- Sits downstream of the DCO as the return path of the code-to-frequency chain: frequency in, digital code out.
- Oscillator input is asynchronous to the clock and is synchronised inside the block.

---
 rtl/dco_freq_meter.sv | 151 +++++++++++++++
 tb/tb_dco_freq_meter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_freq_meter.sv
// DCO frequency meter: counts synchronised rising edges of osc_in over a
// programmable window of gate_len+1 clk cycles and hands the count out with a valid/ready handshake.
module dco_freq_meter #(
    parameter int unsigned COUNT_W = 8,
    parameter int unsigned GATE_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               osc_in,
    input  logic               start,
    input  logic               cont,
    input  logic [GATE_W-1:0]  gate_len,
    output logic               busy,
    output logic [COUNT_W-1:0] result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               ovf
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic [GATE_W-1:0]  timer_q, timer_d;
    logic               cont_q, cont_d;
    logic [COUNT_W-1:0] result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;

    logic               edge_pulse_c;
    logic               sat_c;
    logic [COUNT_W-1:0] cnt_inc_c;

    // Two-flop synchroniser plus history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= osc_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_pulse_c = s2_q & ~s3_q;
    assign sat_c        = edge_pulse_c & (cnt_q == CNT_MAX);
    assign cnt_inc_c    = cnt_q + COUNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ovf_flag_q     <= 1'b0;
            timer_q        <= '0;
            cont_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            ovf_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ovf_flag_q     <= ovf_flag_d;
            timer_q        <= timer_d;
            cont_q         <= cont_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            ovf_q          <= ovf_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ovf_flag_d     = ovf_flag_q;
        timer_d        = timer_q;
        cont_d         = cont_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        ovf_d          = ovf_q;
        busy_d         = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    timer_d    = gate_len;
                    cnt_d      = '0;
                    ovf_flag_d = 1'b0;
                    cont_d     = cont;
                    busy_d     = 1'b1;
                    state_d    = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                timer_d = timer_q - GATE_W'(1);
                if (edge_pulse_c && !sat_c) begin
                    cnt_d = cnt_inc_c;
                end
                if (sat_c) begin
                    ovf_flag_d = 1'b1;
                end
                // Last window cycle: its own edge is folded into the result
                if (timer_q == '0) begin
                    result_d       = (edge_pulse_c && !sat_c) ? cnt_inc_c : cnt_q;
                    ovf_d          = ovf_flag_q | sat_c;
                    result_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end

            ST_DONE: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    if (cont_q) begin
                        timer_d    = gate_len;
                        cnt_d      = '0;
                        ovf_flag_d = 1'b0;
                        cont_d     = cont;
                        state_d    = ST_MEASURE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_dco_freq_meter.sv
// Scoreboard bench for dco_freq_meter: expected results are queued at stimulus
// time and a negedge monitor checks each accepted result against the queue.
module tb_dco_freq_meter;

    logic        clk;
    logic        rst_n;
    logic        osc_in;
    logic        start;
    logic        cont;
    logic [15:0] gate_len;
    logic        busy;
    logic [7:0]  result;
    logic        result_valid;
    logic        result_ready;
    logic        ovf;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Oscillator model: half period in clk cycles, 0 means hold osc_hold
    int   osc_half = 0;
    logic osc_hold = 1'b0;
    int   osc_cnt  = 0;

    dco_freq_meter #(.COUNT_W(8), .GATE_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .osc_in       (osc_in),
        .start        (start),
        .cont         (cont),
        .gate_len     (gate_len),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial osc_in = 1'b0;
    always @(negedge clk) begin
        if (osc_half == 0) begin
            osc_in  = osc_hold;
            osc_cnt = 0;
        end else begin
            osc_cnt++;
            if (osc_cnt >= osc_half) begin
                osc_in  = ~osc_in;
                osc_cnt = 0;
            end
        end
    end

    // Monitor: one pop per accepted result
    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result got result=%0d ovf=%0b, none expected", result, ovf);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || ovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL %s got result=%0d ovf=%0b want result=%0d ovf=%0b",
                             e.name, result, ovf, e.res, e.ovf);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic push(input string name, input logic [7:0] r, input logic o);
        exp_t x;
        x.name = name;
        x.res  = r;
        x.ovf  = o;
        sb.push_back(x);
    endtask

    // Issue start and count clk edges until result_valid; poke adds stray starts and a gate_len change
    task automatic run(input logic [15:0] gl, input logic c, input int limit,
                       input bit poke, output int lat);
        @(posedge clk);
        #1;
        gate_len = gl;
        cont     = c;
        start    = 1'b1;
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start = poke && (lat == 10 || lat == 50);
            if (poke && lat == 20) gate_len = 16'd5;
        end while (!result_valid && lat < limit);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (!result_valid && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    int  lat;
    bit  bad;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        cont         = 1'b0;
        gate_len     = 16'd0;
        result_ready = 1'b0;
        #5;
        check("reset_busy",  32'(busy), 0);
        check("reset_valid", 32'(result_valid), 0);
        check("reset_result", 32'(result), 0);
        check("reset_ovf",   32'(ovf), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic count: 80 ns oscillator, 100-cycle window
        result_ready = 1'b1;
        osc_half     = 2;
        repeat (10) @(posedge clk);
        push("basic", 8'd25, 1'b0);
        run(16'd99, 1'b0, 200, 1'b0, lat);
        check("basic_latency", 32'(lat), 101);
        @(posedge clk);
        #1;
        check("basic_idle_busy", 32'(busy), 0);
        check("basic_idle_valid", 32'(result_valid), 0);

        // Saturation: 40 ns oscillator, 1000-cycle window gives 500 edges
        osc_half = 1;
        repeat (10) @(posedge clk);
        push("saturate", 8'd255, 1'b1);
        run(16'd999, 1'b0, 1200, 1'b0, lat);
        check("saturate_latency", 32'(lat), 1001);
        repeat (3) @(posedge clk);

        // Backpressure with continuous mode
        osc_half     = 2;
        result_ready = 1'b0;
        repeat (10) @(posedge clk);
        push("cont_first", 8'd25, 1'b0);
        push("cont_second", 8'd25, 1'b0);
        run(16'd99, 1'b1, 200, 1'b0, lat);
        check("cont_latency", 32'(lat), 101);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (result !== 8'd25 || ovf !== 1'b0 || result_valid !== 1'b1) bad = 1'b1;
        end
        check("stall_stable", 32'(bad), 0);
        result_ready = 1'b1;
        cont         = 1'b0;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check("after_hs_valid", 32'(result_valid), 0);
        check("after_hs_busy", 32'(busy), 1);
        wait_valid(200, lat);
        check("cont_second_latency", 32'(lat), 100);
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("cont_end_idle", 32'(busy), 0);

        // Minimal window: edge_pulse placed in the single window cycle
        osc_half = 0;
        osc_hold = 1'b0;
        gate_len = 16'd0;
        repeat (10) @(posedge clk);
        push("min_window", 8'd1, 1'b0);
        @(posedge clk);
        #1;
        osc_hold = 1'b1;
        run(16'd0, 1'b0, 20, 1'b0, lat);
        check("min_window_latency", 32'(lat), 2);
        repeat (3) @(posedge clk);

        // Ignored start pulses and gate_len change mid window
        osc_half = 2;
        repeat (10) @(posedge clk);
        push("ignored_start", 8'd25, 1'b0);
        run(16'd99, 1'b0, 200, 1'b1, lat);
        check("ignored_start_latency", 32'(lat), 101);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start_idle", 32'(busy), 0);

        // Reset mid-measurement
        @(posedge clk);
        #1;
        gate_len = 16'd99;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #5;
        check("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_busy",   32'(busy), 0);
        check("rst_valid",  32'(result_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_ovf",    32'(ovf), 0);
        #9;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || result_valid !== 1'b0) bad = 1'b1;
        end
        check("post_reset_quiet", 32'(bad), 0);

        // Zero frequency, osc low then high
        osc_half = 0;
        osc_hold = 1'b0;
        repeat (5) @(posedge clk);
        push("zero_low", 8'd0, 1'b0);
        run(16'd50, 1'b0, 100, 1'b0, lat);
        check("zero_low_latency", 32'(lat), 52);
        repeat (3) @(posedge clk);
        #1;
        osc_hold = 1'b1;
        repeat (5) @(posedge clk);
        push("zero_high", 8'd0, 1'b0);
        run(16'd50, 1'b0, 100, 1'b0, lat);
        check("zero_high_latency", 32'(lat), 52);
        repeat (5) @(posedge clk);

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
